// File: rtl/ps2_command_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, sends start/8 data/odd
// parity/stop bits on device-generated clock edges, then checks the device ack.
module ps2_command_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int BIT_TIMEOUT    = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] command,
    input  logic       send_command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_timed_out
);
    typedef enum logic [3:0] {
        S_IDLE, S_INHIBIT, S_START, S_WAIT_FIRST, S_SHIFT,
        S_ACK, S_RELEASE, S_DONE, S_ERROR
    } state_t;

    state_t      state_q;
    logic [2:0]  clk_sync_q;   // [1:0] synchronizer, [2] previous synchronized level
    logic [1:0]  dat_sync_q;
    logic [31:0] cnt_q;
    logic [3:0]  edge_q;
    logic [7:0]  cmd_q;
    logic        parity_q;
    logic        clk_oe_q, dat_oe_q, busy_q, sent_q, err_q;
    logic        clk_s, dat_s, fall;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];
    assign fall  = clk_sync_q[2] & ~clk_sync_q[1];

    // Idle bus level is high, so the synchronizers reset to 1 to avoid a phantom edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[1], clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            edge_q   <= '0;
            cmd_q    <= '0;
            parity_q <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            sent_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sent_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (send_command) begin
                        cmd_q    <= command;
                        parity_q <= ~^command;
                        cnt_q    <= '0;
                        edge_q   <= '0;
                        clk_oe_q <= 1'b1;
                        dat_oe_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt_q == 32'(INHIBIT_CYCLES - 1)) begin
                        cnt_q    <= '0;
                        dat_oe_q <= 1'b1;
                        state_q  <= S_START;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_START: begin
                    clk_oe_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= S_WAIT_FIRST;
                end
                S_WAIT_FIRST: begin
                    if (fall) begin
                        dat_oe_q <= ~cmd_q[0];
                        edge_q   <= 4'd1;
                        cnt_q    <= '0;
                        state_q  <= S_SHIFT;
                    end else if (cnt_q == 32'(START_TIMEOUT - 1)) begin
                        dat_oe_q <= 1'b0;
                        err_q    <= 1'b1;
                        state_q  <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_SHIFT: begin
                    if (fall) begin
                        cnt_q  <= '0;
                        edge_q <= edge_q + 4'd1;
                        // edge_q holds the count of edges already seen, i.e. the next bit index
                        if (edge_q == 4'd8) begin
                            dat_oe_q <= ~parity_q;
                        end else if (edge_q == 4'd9) begin
                            dat_oe_q <= 1'b0;
                            state_q  <= S_ACK;
                        end else begin
                            dat_oe_q <= ~cmd_q[edge_q[2:0]];
                        end
                    end else if (cnt_q == 32'(BIT_TIMEOUT - 1)) begin
                        dat_oe_q <= 1'b0;
                        err_q    <= 1'b1;
                        state_q  <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_ACK: begin
                    if (fall) begin
                        cnt_q <= '0;
                        if (!dat_s) begin
                            state_q <= S_RELEASE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_ERROR;
                        end
                    end else if (cnt_q == 32'(BIT_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_RELEASE: begin
                    if (clk_s && dat_s) begin
                        sent_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (fall) begin
                        cnt_q <= '0;
                    end else if (cnt_q == 32'(BIT_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= S_ERROR;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_DONE, S_ERROR: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign ps2_clk_oe       = clk_oe_q;
    assign ps2_dat_oe       = dat_oe_q;
    assign busy             = busy_q;
    assign command_was_sent = sent_q;
    assign error_timed_out  = err_q;
endmodule

// File: tb/tb_ps2_command_tx.sv
// Randomized bench with a PS/2 device model; a monitor scores each completion/error
// pulse against a queue of expected outcomes and the frame the device sampled.
module tb_ps2_command_tx;
    localparam int INH = 8;
    localparam int STO = 50;
    localparam int BTO = 100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] command = 8'h00;
    logic       send_command = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe, busy, command_was_sent, error_timed_out;

    // Open-collector bus: either side may pull a line low.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_command_tx #(.INHIBIT_CYCLES(INH), .START_TIMEOUT(STO), .BIT_TIMEOUT(BTO)) dut (
        .clock(clock), .reset(reset), .command(command), .send_command(send_command),
        .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .busy(busy),
        .command_was_sent(command_was_sent), .error_timed_out(error_timed_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       ok;
        logic [7:0] data;
        logic       chk_frame;
    } exp_t;

    exp_t       q[$];
    logic [9:0] frame;
    int         frame_n;
    int         n_cmp = 0;
    int         n_bad = 0;

    localparam int M_ACK = 0, M_NOACK = 1, M_SILENT = 2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic odd_parity(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    // Scoreboard monitor
    always @(negedge clock) begin
        if (!reset && (command_was_sent || error_timed_out)) begin
            chk("pulse_exclusive", {31'd0, command_was_sent & error_timed_out}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, command_was_sent, error_timed_out}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("outcome_sent", {31'd0, command_was_sent}, {31'd0, e.ok});
                chk("outcome_err", {31'd0, error_timed_out}, {31'd0, ~e.ok});
                if (e.chk_frame) begin
                    chk("frame_bits", 32'(frame_n), 32'd10);
                    chk("frame_data", {24'd0, frame[7:0]}, {24'd0, e.data});
                    chk("frame_parity", {31'd0, frame[8]}, {31'd0, odd_parity(e.data)});
                    chk("frame_stop", {31'd0, frame[9]}, 32'd1);
                end
            end
        end
    end

    // Device side of one transfer; abort_k>0 applies reset just after that clock edge.
    task automatic device(input int mode, input int abort_k, input logic inject);
        int inh = 0, st = 0, g = 0, n = 0;
        frame   = 10'h000;
        frame_n = 0;
        while (!ps2_clk_oe && g < 100) begin @(negedge clock); g++; end
        while (ps2_clk_oe && g < 200) begin
            if (ps2_dat_oe) st++; else inh++;
            @(negedge clock); g++;
        end
        chk("inhibit_cycles", 32'(inh), 32'(INH));
        chk("start_cycles", 32'(st), 32'd1);
        chk("start_bit_low", {31'd0, ps2_dat_in}, 32'd0);
        if (mode == M_SILENT) begin
            while (!error_timed_out && n < 200) begin @(negedge clock); n++; end
            chk("start_timeout_cycles", 32'(n), 32'(STO));
            @(negedge clock);
            chk("released_clk", {31'd0, ps2_clk_oe}, 32'd0);
            chk("released_dat", {31'd0, ps2_dat_oe}, 32'd0);
            return;
        end
        repeat (5) @(negedge clock);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) begin
                dev_dat = (mode == M_NOACK) ? 1'b1 : 1'b0;
                repeat (2) @(negedge clock);
            end
            dev_clk = 1'b0;
            if (k == abort_k) begin
                repeat (4) @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                chk("abort_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
                chk("abort_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_pulses", {30'd0, command_was_sent, error_timed_out}, 32'd0);
                reset   = 1'b0;
                dev_clk = 1'b1;
                repeat (5) @(negedge clock);
                return;
            end
            if (inject && k == 3) begin
                command      = 8'h12;
                send_command = 1'b1;
                @(negedge clock);
                send_command = 1'b0;
            end
            repeat (10) @(negedge clock);
            if (k <= 10) begin
                frame[k-1] = ps2_dat_in;
                frame_n++;
            end
            dev_clk = 1'b1;
            repeat (10) @(negedge clock);
        end
        dev_dat = 1'b1;
    endtask

    task automatic transfer(input logic [7:0] b, input int mode, input int abort_k, input logic inject);
        int g = 0;
        if (abort_k == 0) begin
            exp_t e;
            e.ok        = (mode == M_ACK);
            e.data      = b;
            e.chk_frame = (mode != M_SILENT);
            q.push_back(e);
        end
        command      = b;
        send_command = 1'b1;
        @(negedge clock);
        send_command = 1'b0;
        device(mode, abort_k, inject);
        while (busy && g < 300) begin @(negedge clock); g++; end
        chk("return_idle", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clock);
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        chk("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pulses", {30'd0, command_was_sent, error_timed_out}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        transfer(8'hED, M_ACK, 0, 1'b0);
        transfer(8'h00, M_ACK, 0, 1'b0);
        transfer(8'hFF, M_ACK, 0, 1'b0);
        transfer(8'h01, M_ACK, 0, 1'b0);
        transfer(8'h5A, M_SILENT, 0, 1'b0);
        transfer(8'hC3, M_NOACK, 0, 1'b0);
        transfer(8'hF4, M_ACK, 0, 1'b1);
        repeat (30) @(negedge clock);
        chk("no_retrigger", {31'd0, busy}, 32'd0);
        transfer(8'hED, M_ACK, 5, 1'b0);
        transfer(8'hED, M_ACK, 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            logic [7:0] b;
            int m;
            b = 8'($urandom_range(0, 255));
            m = ($urandom_range(0, 3) == 0) ? M_NOACK : M_ACK;
            transfer(b, m, 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_command_tx.md
PS2_COMMAND_TX -- requirements
Module: ps2_command_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000: clock cycles PS/2 clock is held low before the start bit (100 us at 50 MHz).
REQ-002 SHALL have parameter START_TIMEOUT, default 750000: max cycles from clock release to the first device falling edge (15 ms).
REQ-003 SHALL have parameter BIT_TIMEOUT, default 100000: max cycles between consecutive device falling edges (2 ms).
REQ-004 SHALL have port clock, input, 1: single system clock (CLOCK_50); all logic on rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port command, input, 8: byte to send to the keyboard (e.g. 0xED LED command).
REQ-007 SHALL have port send_command, input, 1: request strobe, sampled each cycle.
REQ-008 SHALL have port ps2_clk_in, input, 1: raw PS2_CLK line level (asynchronous).
REQ-009 SHALL have port ps2_dat_in, input, 1: raw PS2_DAT line level (asynchronous).
REQ-010 SHALL have port ps2_clk_oe, output, 1: 1 = pull PS2_CLK low; 0 = release (open-collector).
REQ-011 SHALL have port ps2_dat_oe, output, 1: 1 = pull PS2_DAT low; 0 = release.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port command_was_sent, output, 1: one-cycle pulse on acknowledged transfer.
REQ-014 SHALL have port error_timed_out, output, 1: one-cycle pulse on aborted transfer.

Function
REQ-015 SHALL pass ps2_clk_in and ps2_dat_in each through a 2-flop synchronizer; falling edge = synchronized clk 1 then 0 on consecutive cycles.
REQ-016 SHALL implement states IDLE, INHIBIT, START, WAIT_FIRST, SHIFT, ACK, RELEASE, DONE, ERROR.
REQ-017 IDLE: on send_command=1, latch command, compute odd parity (parity bit = ~^command), go to INHIBIT next cycle.
REQ-018 INHIBIT: ps2_clk_oe=1, ps2_dat_oe=0 for exactly INHIBIT_CYCLES cycles, then START.
REQ-019 START: ps2_clk_oe=1, ps2_dat_oe=1 for exactly 1 cycle, then WAIT_FIRST with ps2_clk_oe=0, ps2_dat_oe=1 (start bit 0).
REQ-020 WAIT_FIRST: on first falling edge, drive bit0 (ps2_dat_oe = ~bit) and enter SHIFT with edge count 1; START_TIMEOUT cycles without edge -> ERROR.
REQ-021 SHIFT: falling edges 2..8 drive bits 1..7 LSB first, edge 9 drives parity, edge 10 releases data (stop bit, ps2_dat_oe=0) and enters ACK.
REQ-022 ACK: on edge 11, synchronized data 0 -> RELEASE; data 1 -> ERROR (no ack).
REQ-023 RELEASE: wait until synchronized clk=1 and dat=1, then DONE.
REQ-024 DONE: command_was_sent=1 for one cycle, return to IDLE; ERROR: error_timed_out=1 for one cycle, both oe=0, return to IDLE.
REQ-025 SHIFT, ACK and RELEASE SHALL each abort to ERROR if BIT_TIMEOUT cycles pass with no qualifying edge/condition; timeout counter clears on every falling edge.
REQ-026 send_command while busy=1 SHALL be ignored; latched command SHALL NOT change mid-transfer.
REQ-027 ps2_clk_oe SHALL be 0 in all states except INHIBIT and START; ps2_dat_oe SHALL be 0 in IDLE, ACK, RELEASE, DONE, ERROR.
REQ-028 command_was_sent and error_timed_out SHALL never be high in the same cycle.

Reset
REQ-029 reset=1 SHALL force IDLE, all counters 0, ps2_clk_oe=0, ps2_dat_oe=0, busy=0, command_was_sent=0, error_timed_out=0 on the next edge.
REQ-030 reset mid-transfer SHALL abort silently (no pulse) and release both lines.

Verification
REQ-031 INHIBIT_CYCLES=8: send 0xED with device model acking -> clk_oe high 8 cycles; data bits 1,0,1,1,0,1,1,1 then parity 1 on edges 1..9; one command_was_sent pulse.
REQ-032 send 0x00 -> parity bit driven 1 (ps2_dat_oe=0) on edge 9; 0xFF -> parity 1; 0x01 -> parity 0.
REQ-033 START_TIMEOUT=50, device never clocks -> error_timed_out pulse exactly 50 cycles after WAIT_FIRST entry; lines released.
REQ-034 device leaves data high on edge 11 -> error_timed_out pulse, no command_was_sent.
REQ-035 send_command asserted again with 0x12 during a 0xF4 transfer -> 0xF4 bits only on the wire, single completion pulse.
REQ-036 reset asserted after edge 5 -> next cycle both oe=0, busy=0, no pulses; a new 0xED request then completes normally.
